// File: rtl/wb_spi_slave_pkg.sv
// Shared definitions for the Wishbone SPI target: register offsets,
// STATUS/CTRL bit positions, link FSM state encoding and a STATUS packer.
package wb_spi_slave_pkg;

  // Register offsets decoded from wb_adr_i[3:2]
  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int ST_RX_AVAIL   = 0;
  localparam int ST_RX_FULL    = 1;
  localparam int ST_TX_EMPTY   = 2;
  localparam int ST_TX_FULL    = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_TX_UNDERRUN = 5;
  localparam int ST_CS_ACTIVE  = 6;

  // CTRL bit positions (interrupt enables)
  localparam int CTRL_RX_IE  = 0;
  localparam int CTRL_TX_IE  = 1;
  localparam int CTRL_ERR_IE = 2;

  // Link FSM states
  typedef enum logic {
    LINK_IDLE  = 1'b0,
    LINK_SHIFT = 1'b1
  } link_state_t;

  // Assemble the 32-bit STATUS word from its individual flags
  function automatic logic [31:0] pack_status(
    input logic rx_avail,
    input logic rx_full,
    input logic tx_empty,
    input logic tx_full,
    input logic rx_overrun,
    input logic tx_underrun,
    input logic cs_active
  );
    return {25'd0, cs_active, tx_underrun, rx_overrun, tx_full, tx_empty, rx_full, rx_avail};
  endfunction

endpackage

// File: rtl/wb_spi_slave_if.sv
// Wishbone slave bus bundle for the SPI target; the master modport is the
// CPU/interconnect side, the slave modport is the peripheral side.
interface wb_spi_slave_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_spi_slave_fifo.sv
// Synchronous byte FIFO used for both the RX and TX paths. Push when full
// and pop when empty are ignored; simultaneous push+pop keeps the count.
// The head entry is presented combinationally on dout.
module spi_slave_fifo #(
  parameter int width      = 8,
  parameter int depth_log2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int depth = 1 << depth_log2;
  localparam logic [depth_log2:0] FULL_COUNT = (depth_log2+1)'(depth);

  logic [width-1:0]      mem_r [depth];
  logic [depth_log2-1:0] wr_ptr_r;
  logic [depth_log2-1:0] rd_ptr_r;
  logic [depth_log2:0]   count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign full      = (count_r == FULL_COUNT);
  assign empty     = (count_r == '0);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];

  // Storage array write; contents need no reset since count guards reads
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/wb_spi_slave.sv
// SPI mode-0 target (8-bit, MSB first) behind a 32-bit Wishbone slave.
// SPI pins are resynchronised into clk; RX/TX byte FIFOs decouple software.
// Optional feature macro: SPI_SLAVE_IRQ_EN (CTRL register and level irq).
module wb_spi_slave
  import wb_spi_slave_pkg::*;
#(
  parameter int fifo_depth_log2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  wb_spi_slave_if.slave       wb,
  input  logic                spi_sck,
  input  logic                spi_cs_n,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic                spi_miso_oe,
  output logic                irq
);
  // Synchroniser and edge-detect state
  logic sck_meta_r, sck_sync_r, sck_dly_r;
  logic cs_meta_r, cs_sync_r, cs_dly_r;
  logic mosi_meta_r, mosi_sync_r;
  logic sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s;

  // Link state
  link_state_t state_r;
  logic [2:0]  bitcnt_r;
  logic [7:0]  rx_shreg_r;
  logic [7:0]  tx_shreg_r;
  logic        byte_done_r;
  logic        miso_r;
  logic        oe_r;

  // FIFO hookup
  logic       rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
  logic [7:0] rx_din_s, rx_dout_s;
  logic       tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
  logic [7:0] tx_dout_s;

  // Link events
  logic       load_evt_s, byte_end_s;
  logic [7:0] load_val_s;
  logic       overrun_set_s, underrun_set_s;

  // Wishbone side
  logic        ack_r;
  logic [31:0] dat_r;
  logic        req_s, wr_s, rd_s;
  logic [1:0]  reg_sel_s;
  logic [31:0] rdata_s, status_s, ctrl_rd_s;
  logic        clr_ov_s, clr_un_s;
  logic        rx_overrun_r, tx_underrun_r;
  logic        irq_r;
  logic        unused_s;

  // Sync chains. cs resets to "asserted" so a cs already low at reset
  // release produces no falling edge until it has been seen high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_meta_r  <= 1'b0;
      sck_sync_r  <= 1'b0;
      sck_dly_r   <= 1'b0;
      cs_meta_r   <= 1'b0;
      cs_sync_r   <= 1'b0;
      cs_dly_r    <= 1'b0;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
    end else begin
      sck_meta_r  <= spi_sck;
      sck_sync_r  <= sck_meta_r;
      sck_dly_r   <= sck_sync_r;
      cs_meta_r   <= spi_cs_n;
      cs_sync_r   <= cs_meta_r;
      cs_dly_r    <= cs_sync_r;
      mosi_meta_r <= spi_mosi;
      mosi_sync_r <= mosi_meta_r;
    end
  end

  assign sck_rise_s = sck_sync_r & ~sck_dly_r;
  assign sck_fall_s = ~sck_sync_r & sck_dly_r;
  assign cs_fall_s  = ~cs_sync_r & cs_dly_r;
  assign cs_rise_s  = cs_sync_r & ~cs_dly_r;

  // A TX load happens on selection and on the falling sck after a full byte
  assign load_evt_s = ((state_r == LINK_IDLE) & cs_fall_s) |
                      ((state_r == LINK_SHIFT) & ~cs_rise_s & sck_fall_s & byte_done_r);
  assign load_val_s     = tx_empty_s ? 8'h00 : tx_dout_s;
  assign tx_pop_s       = load_evt_s & ~tx_empty_s;
  assign underrun_set_s = load_evt_s & tx_empty_s;

  // The 8th rising sck completes a received byte
  assign byte_end_s    = (state_r == LINK_SHIFT) & ~cs_rise_s & sck_rise_s & (bitcnt_r == 3'd7);
  assign rx_din_s      = {rx_shreg_r[6:0], mosi_sync_r};
  assign rx_push_s     = byte_end_s & ~rx_full_s;
  assign overrun_set_s = byte_end_s & rx_full_s;

  // Link FSM: shift registers, bit counter and registered miso/oe
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= LINK_IDLE;
      bitcnt_r    <= 3'd0;
      rx_shreg_r  <= 8'h00;
      tx_shreg_r  <= 8'h00;
      byte_done_r <= 1'b0;
      miso_r      <= 1'b0;
      oe_r        <= 1'b0;
    end else begin
      case (state_r)
        LINK_IDLE: begin
          if (cs_fall_s) begin
            state_r     <= LINK_SHIFT;
            bitcnt_r    <= 3'd0;
            byte_done_r <= 1'b0;
            tx_shreg_r  <= load_val_s;
            miso_r      <= load_val_s[7];
            oe_r        <= 1'b1;
          end
        end
        LINK_SHIFT: begin
          if (cs_rise_s) begin
            state_r     <= LINK_IDLE;
            bitcnt_r    <= 3'd0;
            byte_done_r <= 1'b0;
            miso_r      <= 1'b0;
            oe_r        <= 1'b0;
          end else if (sck_rise_s) begin
            rx_shreg_r  <= rx_din_s;
            bitcnt_r    <= bitcnt_r + 3'd1;
            byte_done_r <= (bitcnt_r == 3'd7);
          end else if (sck_fall_s) begin
            if (byte_done_r) begin
              tx_shreg_r  <= load_val_s;
              miso_r      <= load_val_s[7];
              byte_done_r <= 1'b0;
            end else begin
              tx_shreg_r  <= {tx_shreg_r[6:0], 1'b0};
              miso_r      <= tx_shreg_r[6];
            end
          end
        end
        default: begin
          state_r <= LINK_IDLE;
          oe_r    <= 1'b0;
          miso_r  <= 1'b0;
        end
      endcase
    end
  end

  assign spi_miso    = miso_r;
  assign spi_miso_oe = oe_r;

  spi_slave_fifo #(.width(8), .depth_log2(fifo_depth_log2)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push_s), .pop(rx_pop_s),
    .din(rx_din_s), .dout(rx_dout_s), .full(rx_full_s), .empty(rx_empty_s)
  );

  spi_slave_fifo #(.width(8), .depth_log2(fifo_depth_log2)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push_s), .pop(tx_pop_s),
    .din(wb.wb_dat_i[7:0]), .dout(tx_dout_s), .full(tx_full_s), .empty(tx_empty_s)
  );

  // Wishbone decode; side effects fire on the edge that raises ack
  assign req_s     = wb.wb_stb_i & wb.wb_cyc_i & ~ack_r;
  assign wr_s      = req_s & wb.wb_we_i;
  assign rd_s      = req_s & ~wb.wb_we_i;
  assign reg_sel_s = wb.wb_adr_i[3:2];
  assign rx_pop_s  = rd_s & (reg_sel_s == REG_RXDATA) & ~rx_empty_s;
  assign tx_push_s = wr_s & (reg_sel_s == REG_TXDATA) & ~tx_full_s;
  assign clr_ov_s  = wr_s & (reg_sel_s == REG_STATUS) & wb.wb_dat_i[ST_RX_OVERRUN];
  assign clr_un_s  = wr_s & (reg_sel_s == REG_STATUS) & wb.wb_dat_i[ST_TX_UNDERRUN];

  assign status_s = pack_status(~rx_empty_s, rx_full_s, tx_empty_s, tx_full_s,
                                rx_overrun_r, tx_underrun_r, (state_r == LINK_SHIFT));

  // Read data mux
  always_comb begin
    rdata_s = 32'd0;
    case (reg_sel_s)
      REG_RXDATA: begin
        if (!rx_empty_s) rdata_s = {24'd0, rx_dout_s};
        else             rdata_s = 32'd0;
      end
      REG_STATUS: rdata_s = status_s;
      REG_CTRL:   rdata_s = ctrl_rd_s;
      default:    rdata_s = 32'd0;
    endcase
  end

  // Single-cycle ack and registered read data (zero outside read acks)
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_r <= 1'b0;
      dat_r <= 32'd0;
    end else begin
      ack_r <= req_s;
      dat_r <= rd_s ? rdata_s : 32'd0;
    end
  end

  assign wb.wb_ack_o = ack_r;
  assign wb.wb_dat_o = dat_r;

  // Sticky error flags; a new error wins over a same-cycle W1C clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_overrun_r  <= 1'b0;
      tx_underrun_r <= 1'b0;
    end else begin
      rx_overrun_r  <= overrun_set_s  | (rx_overrun_r  & ~clr_ov_s);
      tx_underrun_r <= underrun_set_s | (tx_underrun_r & ~clr_un_s);
    end
  end

`ifdef SPI_SLAVE_IRQ_EN
  logic [2:0] ctrl_r;

  assign ctrl_rd_s = {29'd0, ctrl_r};

  // CTRL register and registered level interrupt
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_r <= 3'd0;
      irq_r  <= 1'b0;
    end else begin
      if (wr_s && (reg_sel_s == REG_CTRL)) ctrl_r <= wb.wb_dat_i[2:0];
      irq_r <= (ctrl_r[CTRL_RX_IE] & ~rx_empty_s) |
               (ctrl_r[CTRL_TX_IE] & tx_empty_s) |
               (ctrl_r[CTRL_ERR_IE] & (rx_overrun_r | tx_underrun_r));
    end
  end
`else
  assign ctrl_rd_s = 32'd0;

  // Interrupt output held low when the feature is absent
  always_ff @(posedge clk) begin
    if (!rst) irq_r <= 1'b0;
    else      irq_r <= 1'b0;
  end
`endif

  assign irq = irq_r;

  // Bus bits that carry no meaning for this peripheral
  assign unused_s = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i[31:8]};
endmodule
